// File: rtl/character_motion_ctrl.sv
// Per-frame sprite motion controller: gravity, grounded jump, walking,
// collision blocking and play-field clamping, handshaked by enable/done.
module character_motion_ctrl #(
   parameter int POS_W      = 8,
   parameter int JUMP_W     = 6,
   parameter int JUMP_INIT  = 16,
   parameter int FALL_SPEED = 1,
   parameter int WALK_SPEED = 1,
   parameter int X_START    = 72,
   parameter int Y_START    = 0,
   parameter int X_MIN      = 0,
   parameter int X_MAX      = 143,
   parameter int Y_MAX      = 103
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              enable,
   input  logic              jump,
   input  logic              move_left,
   input  logic              move_right,
   input  logic              left_blocked,
   input  logic              right_blocked,
   input  logic              up_blocked,
   input  logic              down_blocked,
   output logic [POS_W-1:0]  x_position,
   output logic [POS_W-1:0]  y_position,
   output logic [JUMP_W-1:0] jump_factor,
   output logic              airborne,
   output logic              done
);

   localparam int SW = POS_W + 2;

   localparam logic signed [SW-1:0] FALL_D = SW'(FALL_SPEED);
   localparam logic signed [SW-1:0] WALK_D = SW'(WALK_SPEED);
   localparam logic signed [SW-1:0] XMIN_S = SW'(X_MIN);
   localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
   localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} ctrl_t;
   typedef enum logic [1:0] {J_GROUND, J_RISING, J_FALLING} jst_t;

   ctrl_t             state, state_nx;
   jst_t              jst, jst_nx;
   logic [JUMP_W-1:0] jf_nx;
   logic [POS_W-1:0]  x_nx, y_nx;
   logic              jump_req;
   logic              calc;

   logic signed [SW-1:0] jf_ext, dy, dx, y_sum, x_sum;

   assign calc = (state == S_CALC);

   // Control FSM state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Control FSM next-state: one calculate cycle per frame request
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (enable)  state_nx = S_CALC;
         S_CALC:               state_nx = S_DONE;
         S_DONE:  if (!enable) state_nx = S_IDLE;
         default:              state_nx = S_IDLE;
      endcase
   end

   // Control FSM outputs
   always_comb begin
      done = (state == S_DONE);
   end

   // Sticky jump request; a press in the consuming cycle survives
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) jump_req <= 1'b0;
      else         jump_req <= jump | (jump_req & ~calc);
   end

   // Jump FSM and motion state register, updated once per frame
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         jst         <= J_FALLING;
         jump_factor <= '0;
         x_position  <= POS_W'(X_START);
         y_position  <= POS_W'(Y_START);
      end else if (calc) begin
         jst         <= jst_nx;
         jump_factor <= jf_nx;
         x_position  <= x_nx;
         y_position  <= y_nx;
      end
   end

   // Jump FSM next-state and impulse bookkeeping
   always_comb begin
      jst_nx = jst;
      jf_nx  = jump_factor;
      unique case (jst)
         J_GROUND: begin
            if (jump_req && down_blocked) begin
               jst_nx = J_RISING;
               jf_nx  = JUMP_W'(JUMP_INIT);
            end else if (!down_blocked) begin
               jst_nx = J_FALLING;
            end
         end
         J_RISING: begin
            if (up_blocked || jump_factor <= JUMP_W'(1)) begin
               jst_nx = J_FALLING;
               jf_nx  = '0;
            end else begin
               jf_nx  = jump_factor - JUMP_W'(1);
            end
         end
         J_FALLING: begin
            jf_nx = '0;
            if (down_blocked) jst_nx = J_GROUND;
         end
         default: begin
            jst_nx = J_FALLING;
            jf_nx  = '0;
         end
      endcase
   end

   // Jump FSM outputs
   always_comb begin
      airborne = (jst != J_GROUND);
   end

   // Position step with saturation to the play-field
   always_comb begin
      jf_ext = $signed({{(SW-JUMP_W){1'b0}}, jump_factor});
      dy     = (down_blocked ? '0 : FALL_D) - (up_blocked ? '0 : jf_ext);
      y_sum  = $signed({2'b00, y_position}) + dy;
      if (y_sum < 0)           y_nx = '0;
      else if (y_sum > YMAX_S) y_nx = POS_W'(Y_MAX);
      else                     y_nx = y_sum[POS_W-1:0];

      dx = '0;
      if (move_right && !right_blocked && !move_left) dx = WALK_D;
      if (move_left && !left_blocked && !move_right)  dx = -WALK_D;
      x_sum = $signed({2'b00, x_position}) + dx;
      if (x_sum < XMIN_S)      x_nx = POS_W'(X_MIN);
      else if (x_sum > XMAX_S) x_nx = POS_W'(X_MAX);
      else                     x_nx = x_sum[POS_W-1:0];
   end

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Bench for character_motion_ctrl: directed scenarios and random frames
// compared against a plain-arithmetic model of sprite motion.
module tb_character_motion_ctrl;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       jump = 1'b0;
   logic       move_left = 1'b0;
   logic       move_right = 1'b0;
   logic       left_blocked = 1'b0;
   logic       right_blocked = 1'b0;
   logic       up_blocked = 1'b0;
   logic       down_blocked = 1'b0;
   logic [7:0] x_position;
   logic [7:0] y_position;
   logic [5:0] jump_factor;
   logic       airborne;
   logic       done;

   int checks = 0;
   int failures = 0;

   // Model: position, impulse, whether on ground / going up, pending jump
   int mx, my, mjf;
   bit m_ground, m_rising, m_req;

   character_motion_ctrl dut (
      .clock(clock), .resetn(resetn), .enable(enable), .jump(jump),
      .move_left(move_left), .move_right(move_right),
      .left_blocked(left_blocked), .right_blocked(right_blocked),
      .up_blocked(up_blocked), .down_blocked(down_blocked),
      .x_position(x_position), .y_position(y_position),
      .jump_factor(jump_factor), .airborne(airborne), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".x"}, int'(x_position), mx);
      chk({tag, ".y"}, int'(y_position), my);
      chk({tag, ".jf"}, int'(jump_factor), mjf);
      chk({tag, ".air"}, int'(airborne), m_ground ? 0 : 1);
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic void model_reset();
      mx = 72; my = 0; mjf = 0;
      m_ground = 0; m_rising = 0; m_req = 0;
   endfunction

   function automatic void model_frame(input bit ml, input bit mr,
      input bit lb, input bit rb, input bit ub, input bit db);
      int dy, dx, old_jf;
      old_jf = mjf;
      dy = (db ? 0 : 1) - (ub ? 0 : old_jf);
      my = clampi(my + dy, 0, 103);
      dx = 0;
      if (mr && !rb && !ml) dx = 1;
      if (ml && !lb && !mr) dx = -1;
      mx = clampi(mx + dx, 0, 143);
      if (m_ground) begin
         if (m_req && db) begin
            m_ground = 0; m_rising = 1; mjf = 16;
         end else if (!db) begin
            m_ground = 0; m_rising = 0;
         end
      end else if (m_rising) begin
         if (ub || old_jf <= 1) begin
            m_rising = 0; mjf = 0;
         end else begin
            mjf = old_jf - 1;
         end
      end else begin
         mjf = 0;
         if (db) m_ground = 1;
      end
      m_req = 0;
   endfunction

   task automatic pulse_jump();
      @(negedge clock); jump = 1'b1;
      @(negedge clock); jump = 1'b0;
      m_req = 1;
   endtask

   // One frame: enable high 4 clocks, low 2 clocks
   task automatic frame(input string tag, input bit ml, input bit mr,
      input bit lb, input bit rb, input bit ub, input bit db);
      @(negedge clock);
      move_left = ml; move_right = mr;
      left_blocked = lb; right_blocked = rb;
      up_blocked = ub; down_blocked = db;
      enable = 1'b1;
      @(negedge clock);
      chk({tag, ".done_calc"}, int'(done), 0);
      @(negedge clock);
      model_frame(ml, mr, lb, rb, ub, db);
      chk({tag, ".done"}, int'(done), 1);
      chk_all(tag);
      move_left = 1'($urandom); move_right = 1'($urandom);
      left_blocked = 1'($urandom); right_blocked = 1'($urandom);
      up_blocked = 1'($urandom); down_blocked = 1'($urandom);
      @(negedge clock);
      @(negedge clock);
      chk({tag, ".done_hold"}, int'(done), 1);
      chk_all({tag, ".hold"});
      enable = 1'b0;
      @(negedge clock);
      chk({tag, ".done_low"}, int'(done), 0);
      @(negedge clock);
   endtask

   initial begin
      model_reset();
      #12;
      chk("reset.done", int'(done), 0);
      chk_all("reset");
      resetn = 1'b1;

      // Free fall from the top
      for (int i = 0; i < 3; i++) frame("fall", 0, 0, 0, 0, 0, 0);
      while (my < 103) frame("fall_fl", 0, 0, 0, 0, 0, 0);
      frame("floor_clamp", 0, 0, 0, 0, 0, 0);
      frame("land", 0, 0, 0, 0, 0, 1);

      // Grounded jump: load impulse, then rise
      pulse_jump();
      frame("jump_acc", 0, 0, 0, 0, 0, 1);
      frame("rise1", 0, 0, 0, 0, 0, 0);
      while (mjf > 10) frame("rise", 0, 0, 0, 0, 0, 0);
      frame("head_bump", 0, 0, 0, 0, 1, 0);
      pulse_jump();
      frame("no_dbl", 0, 0, 0, 0, 0, 0);

      // Full jump from the floor saturates at the top edge
      while (my < 103) frame("refall", 0, 0, 0, 0, 0, 0);
      frame("reland", 0, 0, 0, 0, 0, 1);
      pulse_jump();
      frame("jump2", 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) frame("top_clamp", 0, 0, 0, 0, 0, 0);

      // Horizontal walking and edges
      frame("both", 1, 1, 0, 0, 0, 1);
      frame("lblk", 1, 0, 1, 0, 0, 1);
      frame("rblk", 0, 1, 0, 1, 0, 1);
      while (mx < 143) frame("walk_r", 0, 1, 0, 0, 0, 1);
      frame("right_edge", 0, 1, 0, 0, 0, 1);
      while (mx > 0) frame("walk_l", 1, 0, 0, 0, 0, 1);
      frame("left_edge", 1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 80; i++) frame("walk_back", 0, 1, 0, 0, 0, 0);

      // Random frames
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(3) == 0) pulse_jump();
         frame("rand", 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom_range(3) == 0),
               1'($urandom));
      end

      // Reset while in DONE aborts immediately
      @(negedge clock);
      move_left = 0; move_right = 1; left_blocked = 0;
      right_blocked = 0; up_blocked = 0; down_blocked = 0;
      enable = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("pre_rst.done", int'(done), 1);
      #1 resetn = 1'b0;
      #1;
      model_reset();
      chk("rst_mid.done", int'(done), 0);
      chk_all("rst_mid");
      enable = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      frame("post_rst", 0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
